// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and helpers for the RAM port arbiter.
//   arb_state_t : arbiter FSM state (IDLE = no owner, OWN = owner holds RAM)
//   rr_pick     : round-robin selection, first requester after 'last', wrapping
//   MAX_NREQ    : widest requester vector rr_pick accepts
package ram_arb_pkg;

  localparam int unsigned MAX_NREQ = 32;
  localparam int unsigned MAX_IW   = $clog2(MAX_NREQ);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Scans (last+1) .. (last+n) mod n and returns the first asserted index.
  // Returns 0 when nothing is requesting; callers gate with |req.
  function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] req,
                                          input int unsigned         last,
                                          input int unsigned         n);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= MAX_NREQ; i++) begin
      idx = last + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i <= n)) begin
        if (req[idx[MAX_IW-1:0]]) begin
          found   = 1'b1;
          rr_pick = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of the core-side requests, the testbench override
// and the RAM port of the arbiter.
//   req_ren/req_wen/req_addr/req_store : per-requester request (to arbiter)
//   req_wait/req_load                  : per-requester hold + broadcast read data
//   tb_ctrl/tb_ren/tb_wen/tb_addr/tb_store : testbench override of the RAM port
//   ram_ren/ram_wen/ram_addr/ram_store : arbiter -> RAM
//   ram_load/ram_ready                 : RAM -> arbiter
// Modports: master = environment (cores, testbench, RAM); slave = arbiter.
interface ram_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]         req_ren;
  logic [NREQ-1:0]         req_wen;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_store;
  logic [NREQ-1:0]         req_wait;
  logic [DW-1:0]           req_load;

  logic                    tb_ctrl;
  logic                    tb_ren;
  logic                    tb_wen;
  logic [AW-1:0]           tb_addr;
  logic [DW-1:0]           tb_store;

  logic                    ram_ren;
  logic                    ram_wen;
  logic [AW-1:0]           ram_addr;
  logic [DW-1:0]           ram_store;
  logic [DW-1:0]           ram_load;
  logic                    ram_ready;

  modport master (
    output req_ren, req_wen, req_addr, req_store,
    input  req_wait, req_load,
    output tb_ctrl, tb_ren, tb_wen, tb_addr, tb_store,
    input  ram_ren, ram_wen, ram_addr, ram_store,
    output ram_load, ram_ready
  );

  modport slave (
    input  req_ren, req_wen, req_addr, req_store,
    output req_wait, req_load,
    input  tb_ctrl, tb_ren, tb_wen, tb_addr, tb_store,
    output ram_ren, ram_wen, ram_addr, ram_store,
    input  ram_load, ram_ready
  );
endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector of width NREQ.
//   i_req   : request vector
//   i_last  : index of the previous owner (search starts one past it)
//   o_valid : at least one request asserted
//   o_idx   : winning index
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic            o_valid,
  output logic [IW-1:0]   o_idx
);

  logic [MAX_NREQ-1:0] w_req_ext;

  always_comb begin
    w_req_ext            = '0;
    w_req_ext[NREQ-1:0]  = i_req;
    o_valid              = |i_req;
    o_idx                = IW'(rr_pick(w_req_ext, 32'(i_last), NREQ));
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: N-requester round-robin arbiter for the shared RAM port.
// The grant is registered (IDLE -> OWN) and held until ram_ready or until
// the owner drops its request; tb_ctrl overrides the RAM port at any time.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : ram_arbiter_if.slave (requests, waits, override, RAM port)
// Optional macro RAM_ARB_PERF_EN adds:
//   perf_grants : NREQ x 32 saturating count of completed accesses
//   perf_stall  : NREQ x 32 saturating count of cycles with req_wait=1
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
) (
  input  logic               CLK,
  input  logic               RST,
  ram_arbiter_if.slave       bus
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0] perf_grants,
  output logic [NREQ*32-1:0] perf_stall
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   w_owner_nxt;
  logic [IW-1:0]   w_last_nxt;

  logic [NREQ-1:0] w_req;
  logic            w_pick_valid;
  logic [IW-1:0]   w_pick_idx;
  logic            w_own_ren;
  logic            w_own_wen;
  logic [AW-1:0]   w_own_addr;
  logic [DW-1:0]   w_own_store;
  logic            w_own_act;
  logic            w_done;
  logic [NREQ-1:0] w_wait;

  logic            w_ram_ren;
  logic            w_ram_wen;
  logic [AW-1:0]   w_ram_addr;
  logic [DW-1:0]   w_ram_store;
  logic [DW-1:0]   w_req_load;

  assign w_req       = bus.req_ren | bus.req_wen;
  assign w_own_ren   = bus.req_ren[r_owner];
  assign w_own_wen   = bus.req_wen[r_owner];
  assign w_own_addr  = bus.req_addr[r_owner];
  assign w_own_store = bus.req_store[r_owner];
  assign w_own_act   = (r_state == OWN) && (w_own_ren || w_own_wen);
  // Completion only exists on the core path; the override suppresses it so
  // that every asserted wait stays high while the testbench owns the RAM.
  assign w_done      = (r_state == OWN) && bus.ram_ready && !bus.tb_ctrl;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IW'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    if (bus.tb_ctrl) begin
      // Override aborts any core access without advancing fairness.
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            w_state_nxt = OWN;
            w_owner_nxt = w_pick_idx;
          end
        end
        OWN: begin
          if (!w_own_act || bus.ram_ready) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_owner;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_ram_ren   = 1'b0;
    w_ram_wen   = 1'b0;
    w_ram_addr  = '0;
    w_ram_store = '0;
    w_req_load  = '0;
    if (bus.tb_ctrl) begin
      w_ram_ren   = bus.tb_ren;
      w_ram_wen   = bus.tb_wen;
      w_ram_addr  = bus.tb_addr;
      w_ram_store = bus.tb_store;
    end else if (w_own_act) begin
      w_ram_wen   = w_own_wen;
      w_ram_ren   = w_own_ren && !w_own_wen;
      w_ram_addr  = w_own_addr;
      w_ram_store = w_own_store;
    end
    if (w_done) begin
      w_req_load = bus.ram_load;
    end
  end

  always_comb begin
    w_wait = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_wait[i] = w_req[i] && !(w_done && (r_owner == IW'(i)));
    end
  end

  assign bus.ram_ren   = w_ram_ren;
  assign bus.ram_wen   = w_ram_wen;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_store = w_ram_store;
  assign bus.req_load  = w_req_load;
  assign bus.req_wait  = w_wait;

`ifdef RAM_ARB_PERF_EN
  logic [NREQ-1:0][31:0] r_grants;
  logic [NREQ-1:0][31:0] r_stall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_grants <= '0;
      r_stall  <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (w_done && w_own_act && (r_owner == IW'(i)) && (r_grants[i] != '1)) begin
          r_grants[i] <= r_grants[i] + 32'd1;
        end
        if (w_wait[i] && (r_stall[i] != '1)) begin
          r_stall[i] <= r_stall[i] + 32'd1;
        end
      end
    end
  end

  assign perf_grants = r_grants;
  assign perf_stall  = r_stall;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed, table-driven bench for ram_arbiter with NREQ=4.
// Each table row is one clock cycle: inputs applied just after the rising
// edge, outputs compared 3 ns later. Reset behaviour is covered by hand.
module tb_ram_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_0040;
  localparam logic [31:0] A2 = 32'h0000_2000;
  localparam logic [31:0] A3 = 32'h0000_3000;
  localparam logic [31:0] S0 = 32'h0000_1234;
  localparam logic [31:0] S1 = 32'h0000_00A1;
  localparam logic [31:0] S2 = 32'h0000_00A2;
  localparam logic [31:0] S3 = 32'h0000_00A3;
  localparam logic [31:0] LD = 32'hDEAD_BEEF;
  localparam logic [31:0] TA = 32'h0000_0200;
  localparam logic [31:0] TS = 32'h0000_0055;

  typedef struct {
    string       name;
    logic [3:0]  ren;
    logic [3:0]  wen;
    logic        rdy;
    logic        tbc;
    logic [3:0]  exp_wait;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_store;
    logic [31:0] exp_load;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];

  ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

`ifdef RAM_ARB_PERF_EN
  logic [NREQ*32-1:0] perf_grants;
  logic [NREQ*32-1:0] perf_stall;
`endif

  ram_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
`ifdef RAM_ARB_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stall  (perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic [3:0] ren, input logic [3:0] wen,
                              input logic rdy, input logic tbc, input logic [3:0] ew,
                              input logic er, input logic ewr, input logic [31:0] ea,
                              input logic [31:0] es, input logic [31:0] el);
    vec_t v;
    v.name = nm; v.ren = ren; v.wen = wen; v.rdy = rdy; v.tbc = tbc;
    v.exp_wait = ew; v.exp_ren = er; v.exp_wen = ewr;
    v.exp_addr = ea; v.exp_store = es; v.exp_load = el;
    vecs.push_back(v);
  endfunction

  task automatic check_outputs(input string nm, input logic [3:0] ew, input logic er,
                               input logic ewr, input logic [31:0] ea, input logic [31:0] es,
                               input logic [31:0] el);
    chk({nm, ".req_wait"},  32'(bus.req_wait),  32'(ew));
    chk({nm, ".ram_ren"},   32'(bus.ram_ren),   32'(er));
    chk({nm, ".ram_wen"},   32'(bus.ram_wen),   32'(ewr));
    chk({nm, ".ram_addr"},  bus.ram_addr,       ea);
    chk({nm, ".ram_store"}, bus.ram_store,      es);
    chk({nm, ".req_load"},  bus.req_load,       el);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    bus.req_ren      = '0;
    bus.req_wen      = '0;
    bus.req_addr[0]  = A0;
    bus.req_addr[1]  = A1;
    bus.req_addr[2]  = A2;
    bus.req_addr[3]  = A3;
    bus.req_store[0] = S0;
    bus.req_store[1] = S1;
    bus.req_store[2] = S2;
    bus.req_store[3] = S3;
    bus.tb_ctrl      = 1'b0;
    bus.tb_ren       = 1'b0;
    bus.tb_wen       = 1'b1;
    bus.tb_addr      = TA;
    bus.tb_store     = TS;
    bus.ram_load     = LD;
    bus.ram_ready    = 1'b0;
    rst              = 1'b0;

    // Fairness from reset: last = 3, so grants run 0,1,2,3,0 with an IDLE gap.
    add("f_idle0", 4'hF, 4'h0, 1, 0, 4'hF, 0, 0, 0,  0,  0);
    add("f_own0",  4'hF, 4'h0, 1, 0, 4'hE, 1, 0, A0, S0, LD);
    add("f_idle1", 4'hF, 4'h0, 1, 0, 4'hF, 0, 0, 0,  0,  0);
    add("f_own1",  4'hF, 4'h0, 1, 0, 4'hD, 1, 0, A1, S1, LD);
    add("f_idle2", 4'hF, 4'h0, 1, 0, 4'hF, 0, 0, 0,  0,  0);
    add("f_own2",  4'hF, 4'h0, 1, 0, 4'hB, 1, 0, A2, S2, LD);
    add("f_idle3", 4'hF, 4'h0, 1, 0, 4'hF, 0, 0, 0,  0,  0);
    add("f_own3",  4'hF, 4'h0, 1, 0, 4'h7, 1, 0, A3, S3, LD);
    add("f_idle4", 4'hF, 4'h0, 1, 0, 4'hF, 0, 0, 0,  0,  0);
    add("f_own0b", 4'hF, 4'h0, 1, 0, 4'hE, 1, 0, A0, S0, LD);
    // Single read by requester 1, ready in its third cycle; ready in IDLE ignored.
    add("rd_arb",  4'h2, 4'h0, 0, 0, 4'h2, 0, 0, 0,  0,  0);
    add("rd_own1", 4'h2, 4'h0, 0, 0, 4'h2, 1, 0, A1, S1, 0);
    add("rd_own2", 4'h2, 4'h0, 0, 0, 4'h2, 1, 0, A1, S1, 0);
    add("rd_done", 4'h2, 4'h0, 1, 0, 4'h0, 1, 0, A1, S1, LD);
    add("rd_idle", 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 0,  0,  0);
    // Write beats read when both are set.
    add("wr_arb",  4'h1, 4'h1, 0, 0, 4'h1, 0, 0, 0,  0,  0);
    add("wr_own",  4'h1, 4'h1, 1, 0, 4'h0, 0, 1, A0, S0, LD);
    add("wr_idle", 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0,  0,  0);
    // Abort by owner 1; last becomes 1, so 0 beats 1 on re-arbitration.
    add("ab_arb",  4'h2, 4'h0, 0, 0, 4'h2, 0, 0, 0,  0,  0);
    add("ab_own",  4'h2, 4'h0, 0, 0, 4'h2, 1, 0, A1, S1, 0);
    add("ab_drop", 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0,  0,  0);
    add("ab_rearb",4'h3, 4'h0, 0, 0, 4'h3, 0, 0, 0,  0,  0);
    add("ab_own0", 4'h3, 4'h0, 1, 0, 4'h2, 1, 0, A0, S0, LD);
    add("ab_idle", 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0,  0,  0);
    // Testbench override during core 0's access, then core 0 re-granted.
    add("ov_arb",  4'h1, 4'h0, 0, 0, 4'h1, 0, 0, 0,  0,  0);
    add("ov_own",  4'h1, 4'h0, 0, 0, 4'h1, 1, 0, A0, S0, 0);
    add("ov_take", 4'h1, 4'h0, 0, 1, 4'h1, 0, 1, TA, TS, 0);
    add("ov_hold", 4'h1, 4'h0, 0, 1, 4'h1, 0, 1, TA, TS, 0);
    add("ov_rel",  4'h1, 4'h0, 0, 0, 4'h1, 0, 0, 0,  0,  0);
    add("ov_own0", 4'h1, 4'h0, 1, 0, 4'h0, 1, 0, A0, S0, LD);
    add("ov_idle", 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0,  0,  0);

    // Reset state: outputs zero, waits follow requests even while in reset.
    #1;
    rst           = 1'b1;
    bus.req_ren   = 4'h5;
    bus.ram_ready = 1'b1;
    #2;
    check_outputs("reset", 4'h5, 0, 0, 0, 0, 0);
`ifdef RAM_ARB_PERF_EN
    chk("reset.perf_grants", 32'(perf_grants != '0), 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_ren   = 4'h0;
    bus.ram_ready = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      bus.req_ren   = vecs[i].ren;
      bus.req_wen   = vecs[i].wen;
      bus.ram_ready = vecs[i].rdy;
      bus.tb_ctrl   = vecs[i].tbc;
      #3;
      check_outputs(vecs[i].name, vecs[i].exp_wait, vecs[i].exp_ren, vecs[i].exp_wen,
                    vecs[i].exp_addr, vecs[i].exp_store, vecs[i].exp_load);
    end

    // Async reset while requester 1 owns the RAM: outputs drop before any edge.
    @(posedge clk);
    #1;
    bus.req_ren   = 4'h2;
    bus.req_wen   = 4'h0;
    bus.ram_ready = 1'b0;
    bus.tb_ctrl   = 1'b0;
    @(posedge clk);
    #3;
    check_outputs("ar_own", 4'h2, 1, 0, A1, S1, 0);
    #1;
    rst = 1'b1;
    #1;
    check_outputs("ar_async", 4'h2, 0, 0, 0, 0, 0);
`ifdef RAM_ARB_PERF_EN
    chk("ar_async.perf_grants", 32'(perf_grants != '0), 32'd0);
    chk("ar_async.perf_stall",  32'(perf_stall != '0),  32'd0);
`endif
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.req_ren = 4'h3;
    #3;
    check_outputs("ar_rearb", 4'h3, 0, 0, 0, 0, 0);
    // last returned to NREQ-1, so requester 0 wins the tie.
    @(posedge clk);
    #3;
    check_outputs("ar_own0", 4'h3, 1, 0, A0, S0, 0);
    #1;
    bus.req_ren = 4'h0;

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
